// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares one write port between the RW stage and a
// FIFO-buffered long-latency unit, with starvation relief and end-of-program draining.
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rw_isWb,
  input  logic [3:0]  rw_rd,
  input  logic [31:0] rw_data,
  input  logic        is_last_instruction,
  input  logic        llu_valid,
  input  logic [3:0]  llu_rd,
  input  logic [31:0] llu_data,
  input  logic        llu_busy,
  output logic        llu_ready,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic        halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e state_q, state_d;

  logic [3:0]       fifo_rd_q   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic        rf_we_q;
  logic [3:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  logic fifo_empty, fifo_full, push, grant_rw, grant_fifo;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FULL_OCC);
  assign llu_ready  = ~fifo_full;
  // Results offered after halting are never retired, so they are not stored either.
  assign push       = llu_valid & ~fifo_full & (state_q != StHalted);

  always_comb begin
    state_d    = state_q;
    pipe_stall = 1'b0;
    halted     = 1'b0;
    grant_rw   = 1'b0;
    grant_fifo = 1'b0;
    case (state_q)
      StRun: begin
        pipe_stall = (wait_cnt_q == WAIT_LIMIT);
        grant_rw   = ~pipe_stall & rw_isWb;
        grant_fifo = ~grant_rw & ~fifo_empty;
        if (is_last_instruction && !pipe_stall) state_d = StDrain;
      end
      StDrain: begin
        pipe_stall = 1'b1;
        grant_fifo = ~fifo_empty;
        if (fifo_empty && !llu_busy && !llu_valid) state_d = StHalted;
      end
      StHalted: begin
        pipe_stall = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || grant_fifo) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (push)       wr_ptr_q <= wr_ptr_q + 1'b1;
      if (grant_fifo) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !grant_fifo) begin
        occ_q <= occ_q + 1'b1;
      end else if (!push && grant_fifo) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= llu_rd;
      fifo_data_q[wr_ptr_q] <= llu_data;
    end
  end

  // Address/data hold their last granted values while rf_we is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant_rw | grant_fifo;
      if (grant_rw) begin
        rf_waddr_q <= rw_rd;
        rf_wdata_q <= rw_data;
      end else if (grant_fifo) begin
        rf_waddr_q <= fifo_rd_q[rd_ptr_q];
        rf_wdata_q <= fifo_data_q[rd_ptr_q];
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, scripted drain/reset sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rw_isWb;
  logic [3:0]  rw_rd;
  logic [31:0] rw_data;
  logic        is_last_instruction;
  logic        llu_valid;
  logic [3:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_busy;
  logic        llu_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        halted;

  wb_port_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rw_isWb             (rw_isWb),
    .rw_rd               (rw_rd),
    .rw_data             (rw_data),
    .is_last_instruction (is_last_instruction),
    .llu_valid           (llu_valid),
    .llu_rd              (llu_rd),
    .llu_data            (llu_data),
    .llu_busy            (llu_busy),
    .llu_ready           (llu_ready),
    .rf_we               (rf_we),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata),
    .pipe_stall          (pipe_stall),
    .halted              (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        wb;
    logic [3:0]  rd;
    logic [31:0] wd;
    logic        lv;
    logic [3:0]  lrd;
    logic [31:0] ld;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of pending results, wait age of the head, program phase.
  ent_t        mq[$];
  int          m_wait;
  int          m_mode;  // 0 running, 1 draining, 2 halted
  logic        m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; rw_isWb = 1'b0; rw_rd = '0; rw_data = '0; is_last_instruction = 1'b0;
    llu_valid = 1'b0; llu_rd = '0; llu_data = '0; llu_busy = 1'b0;
  endtask

  // Advance the model on the current inputs, clock once, then compare every output.
  task automatic step();
    bit   stall, grw, gff, had, room;
    int   nmode;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_wait = 0; m_mode = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      stall = (m_mode != 0) || (m_wait == MAX_WAIT);
      had   = mq.size() > 0;
      room  = mq.size() < DEPTH;
      grw   = !stall && rw_isWb;
      gff   = !grw && m_mode != 2 && had;
      nmode = m_mode;
      if (m_mode == 0 && is_last_instruction && !stall) nmode = 1;
      if (m_mode == 1 && !had && !llu_busy && !llu_valid) nmode = 2;
      m_we = grw || gff;
      if (grw) begin
        m_addr = rw_rd; m_data = rw_data;
      end else if (gff) begin
        e = mq.pop_front(); m_addr = e.rd; m_data = e.d;
      end
      if (!had || gff) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (llu_valid && room && m_mode != 2) mq.push_back({llu_rd, llu_data});
      m_mode = nmode;
    end
    @(posedge clk);
    #1;
    chk("model rf_we", rf_we, m_we);
    chk("model rf_waddr", rf_waddr, m_addr);
    chk("model rf_wdata", rf_wdata, m_data);
    chk("model pipe_stall", pipe_stall, (m_mode != 0) || (m_wait == MAX_WAIT));
    chk("model llu_ready", llu_ready, mq.size() < DEPTH);
    chk("model halted", halted, m_mode == 2);
  endtask

  vec_t tbl [21];
  ent_t wr_log[$];
  int   halt_at;

  initial begin
    // rst wb rd wd | lv lrd ld | we addr data stall ready
    tbl[0]  = '{1, 0, 0, 0,            1, 1, 32'h11,   0, 0, 0,            0, 1};
    tbl[1]  = '{1, 0, 0, 0,            1, 1, 32'h11,   0, 0, 0,            0, 1};
    tbl[2]  = '{0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1};
    tbl[3]  = '{0, 1, 3, 32'hA5A50001, 1, 5, 32'h1234, 1, 3, 32'hA5A50001, 0, 1};
    tbl[4]  = '{0, 0, 0, 0,            0, 0, 0,        1, 5, 32'h1234,     0, 1};
    tbl[5]  = '{0, 0, 0, 0,            0, 0, 0,        0, 5, 32'h1234,     0, 1};
    tbl[6]  = '{0, 1, 1, 32'h100,      1, 8, 32'hB0,   1, 1, 32'h100,      0, 1};
    tbl[7]  = '{0, 1, 2, 32'h200,      1, 9, 32'hB1,   1, 2, 32'h200,      0, 0};
    tbl[8]  = '{0, 1, 3, 32'h300,      1, 10, 32'hB2,  1, 3, 32'h300,      0, 0};
    tbl[9]  = '{0, 0, 0, 0,            1, 10, 32'hB2,  1, 8, 32'hB0,       0, 1};
    tbl[10] = '{0, 0, 0, 0,            1, 10, 32'hB2,  1, 9, 32'hB1,       0, 1};
    tbl[11] = '{0, 0, 0, 0,            0, 0, 0,        1, 10, 32'hB2,      0, 1};
    tbl[12] = '{0, 0, 0, 0,            0, 0, 0,        0, 10, 32'hB2,      0, 1};
    tbl[13] = '{0, 0, 0, 0,            1, 7, 32'hDEAD, 0, 10, 32'hB2,      0, 1};
    tbl[14] = '{0, 1, 4, 32'h400,      0, 0, 0,        1, 4, 32'h400,      0, 1};
    tbl[15] = '{0, 1, 4, 32'h401,      0, 0, 0,        1, 4, 32'h401,      0, 1};
    tbl[16] = '{0, 1, 4, 32'h402,      0, 0, 0,        1, 4, 32'h402,      0, 1};
    tbl[17] = '{0, 1, 4, 32'h403,      0, 0, 0,        1, 4, 32'h403,      1, 1};
    tbl[18] = '{0, 1, 4, 32'h404,      0, 0, 0,        1, 7, 32'hDEAD,     0, 1};
    tbl[19] = '{0, 1, 4, 32'h404,      0, 0, 0,        1, 4, 32'h404,      0, 1};
    tbl[20] = '{0, 0, 0, 0,            0, 0, 0,        0, 4, 32'h404,      0, 1};

    idle();
    for (int i = 0; i < 21; i++) begin
      reset = tbl[i].rst; rw_isWb = tbl[i].wb; rw_rd = tbl[i].rd; rw_data = tbl[i].wd;
      llu_valid = tbl[i].lv; llu_rd = tbl[i].lrd; llu_data = tbl[i].ld;
      step();
      chk($sformatf("vec%0d rf_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("vec%0d rf_waddr", i), rf_waddr, tbl[i].e_addr);
      chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].e_data);
      chk($sformatf("vec%0d pipe_stall", i), pipe_stall, tbl[i].e_stall);
      chk($sformatf("vec%0d llu_ready", i), llu_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d halted", i), halted, 1'b0);
    end

    // Halt drain: two buffered results, LLU busy for 5 cycles, then a third result.
    idle();
    rw_isWb = 1; rw_rd = 11; rw_data = 32'h500; llu_valid = 1; llu_rd = 1; llu_data = 32'hC0;
    llu_busy = 1;
    step();
    rw_rd = 12; rw_data = 32'h501; llu_rd = 2; llu_data = 32'hC1;
    step();
    rw_isWb = 0; llu_valid = 0; is_last_instruction = 1;
    step();
    if (rf_we) wr_log.push_back({rf_waddr, rf_wdata});
    is_last_instruction = 0; rw_isWb = 1; rw_rd = 13; rw_data = 32'h600;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_we) wr_log.push_back({rf_waddr, rf_wdata});
    end
    llu_busy = 0; llu_valid = 1; llu_rd = 3; llu_data = 32'hC2;
    step();
    if (rf_we) wr_log.push_back({rf_waddr, rf_wdata});
    llu_valid = 0;
    halt_at = -1;
    for (int i = 0; i < 10 && halt_at < 0; i++) begin
      step();
      if (rf_we) wr_log.push_back({rf_waddr, rf_wdata});
      if (halted) halt_at = i;
    end
    chk("drain halt latency", halt_at, 1);
    chk("drain write count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain write%0d", i), (i < wr_log.size()) ? wr_log[i] : '0,
          {4'(i + 1), 32'hC0 + 32'(i)});
    end

    // Halted holds with no grants regardless of requests.
    rw_isWb = 1; llu_valid = 1; llu_rd = 6; llu_data = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halted no write", rf_we, 1'b0);
      chk("halted stays", halted, 1'b1);
      chk("halted ready", llu_ready, 1'b1);
    end
    reset = 1;
    step();
    chk("reset from halt halted", halted, 1'b0);
    chk("reset from halt stall", pipe_stall, 1'b0);

    // Reset while draining discards buffered results.
    idle();
    rw_isWb = 1; rw_rd = 14; rw_data = 32'h700; llu_valid = 1; llu_rd = 4; llu_data = 32'hD0;
    step();
    rw_isWb = 0; is_last_instruction = 1; llu_busy = 1; llu_rd = 5; llu_data = 32'hD1;
    step();
    chk("drain entered", pipe_stall, 1'b1);
    reset = 1;
    step();
    chk("reset from drain stall", pipe_stall, 1'b0);
    chk("reset from drain ready", llu_ready, 1'b1);
    idle();
    step();
    chk("fifo flushed by reset", rf_we, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
      rw_isWb = ($urandom_range(0, 3) != 0);
      rw_rd = 4'($urandom); rw_data = $urandom;
      is_last_instruction = ($urandom_range(0, 59) == 0);
      llu_valid = $urandom_range(0, 1) == 1;
      llu_rd = 4'($urandom); llu_data = $urandom;
      llu_busy = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
